// File: rtl/cache_lookup_plru_if.sv
// Request/response bundle for cache_lookup_plru: set-array read in, lookup result out.
// The master drives requests and consumes responses; the lookup block is the slave.
interface cache_lookup_plru_if #(
    parameter int WAYS     = 8,
    parameter int TAG      = 12,
    parameter int INDEX    = 14,
    parameter int WAYS_REP = $clog2(WAYS)
);
    logic                  req_valid;
    logic                  req_ready;
    logic [INDEX-1:0]      req_index;
    logic [TAG-1:0]        req_tag;
    logic [WAYS*TAG-1:0]   req_tags;
    logic [WAYS*2-1:0]     req_mesi;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_hit;
    logic [WAYS_REP-1:0]   rsp_way;
    logic                  rsp_multi_hit;
    logic [WAYS_REP-1:0]   rsp_victim;
    logic                  rsp_victim_dirty;

    modport master (
        output req_valid, req_index, req_tag, req_tags, req_mesi, rsp_ready,
        input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_multi_hit, rsp_victim, rsp_victim_dirty
    );

    modport slave (
        input  req_valid, req_index, req_tag, req_tags, req_mesi, rsp_ready,
        output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_multi_hit, rsp_victim, rsp_victim_dirty
    );
endinterface

// File: rtl/cache_lookup_plru.sv
// Pipelined N-way tag lookup with per-set tree pseudo-LRU victim selection.
// Define CACHE_LOOKUP_STATS_EN to add saturating hit/miss counters.
module cache_lookup_plru #(
    parameter int WAYS     = 8,
    parameter int TAG      = 12,
    parameter int INDEX    = 14,
    parameter int WAYS_REP = $clog2(WAYS)
) (
    input  logic                 clk,
    input  logic                 rstb,
    cache_lookup_plru_if.slave   bus
`ifdef CACHE_LOOKUP_STATS_EN
    ,
    output logic [31:0]          stat_hits,
    output logic [31:0]          stat_misses
`endif
);
    // MESI encoding shared with the cache structures: I=00, S=01, E=10, M=11.
    localparam logic [1:0] MESI_I = 2'b00;
    localparam logic [1:0] MESI_M = 2'b11;
    localparam int NODES = WAYS - 1;
    localparam int SETS  = 1 << INDEX;

    logic                s1_valid_q, s1_valid_d;
    logic [INDEX-1:0]    s1_index_q, s1_index_d;
    logic [TAG-1:0]      s1_tag_q,   s1_tag_d;
    logic [WAYS*TAG-1:0] s1_tags_q,  s1_tags_d;
    logic [WAYS*2-1:0]   s1_mesi_q,  s1_mesi_d;

    logic                rsp_valid_q,  rsp_valid_d;
    logic                rsp_hit_q,    rsp_hit_d;
    logic [WAYS_REP-1:0] rsp_way_q,    rsp_way_d;
    logic                rsp_multi_q,  rsp_multi_d;
    logic [WAYS_REP-1:0] rsp_victim_q, rsp_victim_d;
    logic                rsp_dirty_q,  rsp_dirty_d;

    logic [NODES-1:0]    plru_q [SETS];
    logic [NODES-1:0]    plru_rd;
    logic [NODES-1:0]    plru_wdata;

    logic                advance, req_ready, accept, update;
    logic [WAYS-1:0]     match, invalid;
    logic                hit, multi_hit, any_invalid, victim_dirty;
    logic [WAYS_REP-1:0] hit_way, inv_way, plru_way, victim, touched;

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        assign match[gi]   = (s1_tags_q[gi*TAG +: TAG] == s1_tag_q) &&
                             (s1_mesi_q[gi*2 +: 2] != MESI_I);
        assign invalid[gi] = (s1_mesi_q[gi*2 +: 2] == MESI_I);
    end

    // Compare, victim choice and PLRU path update, all from the S1 entry.
    always_comb begin
        int node;
        plru_rd     = plru_q[s1_index_q];
        hit         = |match;
        multi_hit   = |(match & (match - WAYS'(1)));
        any_invalid = |invalid;
        hit_way     = '0;
        inv_way     = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w])   hit_way = WAYS_REP'(w);
            if (invalid[w]) inv_way = WAYS_REP'(w);
        end

        plru_way = '0;
        node     = 0;
        for (int l = 0; l < WAYS_REP; l++) begin
            plru_way[WAYS_REP-1-l] = plru_rd[node];
            node = 2 * node + 1 + int'(plru_rd[node]);
        end

        victim       = any_invalid ? inv_way : plru_way;
        victim_dirty = (s1_mesi_q[victim*2 +: 2] == MESI_M);
        touched      = hit ? hit_way : victim;

        // Each node on the touched path is flipped to point at the other subtree.
        plru_wdata = plru_rd;
        node       = 0;
        for (int l = 0; l < WAYS_REP; l++) begin
            plru_wdata[node] = ~touched[WAYS_REP-1-l];
            node = 2 * node + 1 + int'(touched[WAYS_REP-1-l]);
        end
    end

    always_comb begin
        advance   = !rsp_valid_q || bus.rsp_ready;
        req_ready = !s1_valid_q || advance;
        accept    = bus.req_valid && req_ready;
        update    = advance && s1_valid_q;

        s1_valid_d = accept ? 1'b1 : (advance ? 1'b0 : s1_valid_q);
        s1_index_d = s1_index_q;
        s1_tag_d   = s1_tag_q;
        s1_tags_d  = s1_tags_q;
        s1_mesi_d  = s1_mesi_q;
        if (accept) begin
            s1_index_d = bus.req_index;
            s1_tag_d   = bus.req_tag;
            s1_tags_d  = bus.req_tags;
            s1_mesi_d  = bus.req_mesi;
        end

        rsp_valid_d  = rsp_valid_q;
        rsp_hit_d    = rsp_hit_q;
        rsp_way_d    = rsp_way_q;
        rsp_multi_d  = rsp_multi_q;
        rsp_victim_d = rsp_victim_q;
        rsp_dirty_d  = rsp_dirty_q;
        if (advance) rsp_valid_d = s1_valid_q;
        if (update) begin
            rsp_hit_d    = hit;
            rsp_way_d    = hit_way;
            rsp_multi_d  = multi_hit;
            rsp_victim_d = victim;
            rsp_dirty_d  = victim_dirty;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s1_valid_q   <= 1'b0;
            s1_index_q   <= '0;
            s1_tag_q     <= '0;
            s1_tags_q    <= '0;
            s1_mesi_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_way_q    <= '0;
            rsp_multi_q  <= 1'b0;
            rsp_victim_q <= '0;
            rsp_dirty_q  <= 1'b0;
            for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_index_q   <= s1_index_d;
            s1_tag_q     <= s1_tag_d;
            s1_tags_q    <= s1_tags_d;
            s1_mesi_q    <= s1_mesi_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_hit_q    <= rsp_hit_d;
            rsp_way_q    <= rsp_way_d;
            rsp_multi_q  <= rsp_multi_d;
            rsp_victim_q <= rsp_victim_d;
            rsp_dirty_q  <= rsp_dirty_d;
            if (update) plru_q[s1_index_q] <= plru_wdata;
        end
    end

    assign bus.req_ready        = req_ready;
    assign bus.rsp_valid        = rsp_valid_q;
    assign bus.rsp_hit          = rsp_hit_q;
    assign bus.rsp_way          = rsp_way_q;
    assign bus.rsp_multi_hit    = rsp_multi_q;
    assign bus.rsp_victim       = rsp_victim_q;
    assign bus.rsp_victim_dirty = rsp_dirty_q;

`ifdef CACHE_LOOKUP_STATS_EN
    logic [31:0] stat_hits_q, stat_hits_d;
    logic [31:0] stat_misses_q, stat_misses_d;

    always_comb begin
        stat_hits_d   = stat_hits_q;
        stat_misses_d = stat_misses_q;
        if (update && hit && (stat_hits_q != 32'hFFFF_FFFF))
            stat_hits_d = stat_hits_q + 32'd1;
        if (update && !hit && (stat_misses_q != 32'hFFFF_FFFF))
            stat_misses_d = stat_misses_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else begin
            stat_hits_q   <= stat_hits_d;
            stat_misses_q <= stat_misses_d;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`endif
endmodule

// File: tb/tb_cache_lookup_plru.sv
// Directed bench for cache_lookup_plru: vector table plus stall and reset sequences.
module tb_cache_lookup_plru;
    localparam int WAYS  = 8;
    localparam int TAG   = 12;
    localparam int INDEX = 14;
    localparam logic [1:0] ST_I = 2'b00, ST_S = 2'b01, ST_E = 2'b10, ST_M = 2'b11;

    typedef logic [WAYS-1:0][TAG-1:0] tags_t;
    typedef logic [WAYS-1:0][1:0]     mesi_t;

    typedef struct {
        logic [INDEX-1:0] idx;
        logic [TAG-1:0]   tag;
        tags_t            tags;
        mesi_t            mesi;
        logic             hit;
        logic [2:0]       way;
        logic             multi;
        logic             chk_victim;
        logic [2:0]       victim;
        logic             dirty;
    } vec_t;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    cache_lookup_plru_if #(.WAYS(WAYS), .TAG(TAG), .INDEX(INDEX)) bus ();

`ifdef CACHE_LOOKUP_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    cache_lookup_plru #(.WAYS(WAYS), .TAG(TAG), .INDEX(INDEX)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
`ifdef CACHE_LOOKUP_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    vec_t       vecs [16];
    logic       r_hit, r_multi, r_dirty;
    logic [2:0] r_way, r_victim;
    int         r_lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t blank(input logic [INDEX-1:0] idx, input logic [TAG-1:0] tag);
        vec_t v;
        v.idx = idx; v.tag = tag; v.tags = '0; v.mesi = '0;
        v.hit = 1'b0; v.way = 3'd0; v.multi = 1'b0;
        v.chk_victim = 1'b0; v.victim = 3'd0; v.dirty = 1'b0;
        return v;
    endfunction

    task automatic drive(input logic [INDEX-1:0] idx, input logic [TAG-1:0] tag,
                         input tags_t tags, input mesi_t mesi);
        bus.req_index = idx;
        bus.req_tag   = tag;
        bus.req_tags  = tags;
        bus.req_mesi  = mesi;
        bus.req_valid = 1'b1;
    endtask

    // One isolated lookup with rsp_ready high; r_lat counts cycles from acceptance to rsp_valid.
    task automatic lookup(input logic [INDEX-1:0] idx, input logic [TAG-1:0] tag,
                          input tags_t tags, input mesi_t mesi);
        bit acc;
        acc = 1'b0;
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        drive(idx, tag, tags, mesi);
        for (int n = 0; n < 20 && !acc; n++) begin
            if (bus.req_ready) acc = 1'b1;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        check("accept", 32'(acc), 32'd1);
        r_lat = 0;
        while (!bus.rsp_valid && r_lat < 20) begin
            @(negedge clk);
            r_lat++;
        end
        r_hit    = bus.rsp_hit;
        r_way    = bus.rsp_way;
        r_multi  = bus.rsp_multi_hit;
        r_victim = bus.rsp_victim;
        r_dirty  = bus.rsp_victim_dirty;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tags_t ta;
        mesi_t ma;
        logic [2:0] seq_victims [8];

        seq_victims = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

        vecs[0] = blank(14'd5, 12'h123);
        vecs[0].tags[0] = 12'h123;
        vecs[0].chk_victim = 1'b1;

        vecs[1] = blank(14'd6, 12'h0AB);
        vecs[1].tags[3] = 12'h0AB; vecs[1].mesi[3] = ST_S;
        vecs[1].tags[6] = 12'h0AB; vecs[1].mesi[6] = ST_I;
        vecs[1].hit = 1'b1; vecs[1].way = 3'd3;

        vecs[2] = blank(14'd7, 12'h055);
        for (int w = 0; w < WAYS; w++) vecs[2].tags[w] = 12'h055;
        vecs[2].mesi[2] = ST_E; vecs[2].mesi[5] = ST_M;
        vecs[2].hit = 1'b1; vecs[2].way = 3'd2; vecs[2].multi = 1'b1;

        vecs[3] = blank(14'd8, 12'h100);
        for (int w = 0; w < WAYS; w++) begin
            vecs[3].tags[w] = 12'h100 + 12'(w);
            vecs[3].mesi[w] = ST_S;
        end
        vecs[3].hit = 1'b1; vecs[3].way = 3'd0;

        vecs[4] = vecs[3];
        vecs[4].tag = 12'h200; vecs[4].hit = 1'b0; vecs[4].way = 3'd0;
        vecs[4].chk_victim = 1'b1; vecs[4].victim = 3'd4; vecs[4].dirty = 1'b0;

        vecs[5] = blank(14'd10, 12'h101);
        for (int w = 0; w < WAYS; w++) begin
            vecs[5].tags[w] = 12'h100 + 12'(w);
            vecs[5].mesi[w] = ST_M;
        end
        vecs[5].mesi[1] = ST_I; vecs[5].mesi[6] = ST_I;
        vecs[5].chk_victim = 1'b1; vecs[5].victim = 3'd1; vecs[5].dirty = 1'b0;

        vecs[6] = blank(14'h3FFF, 12'hFFF);
        for (int w = 0; w < WAYS; w++) begin
            vecs[6].tags[w] = 12'h100 + 12'(w);
            vecs[6].mesi[w] = ST_S;
        end
        vecs[6].tags[7] = 12'hFFF; vecs[6].mesi[7] = ST_M;
        vecs[6].hit = 1'b1; vecs[6].way = 3'd7;

        for (int k = 0; k < 9; k++) begin
            vecs[7+k] = blank(14'd9, 12'h3FF);
            for (int w = 0; w < WAYS; w++) begin
                vecs[7+k].tags[w] = 12'h300 + 12'(w);
                vecs[7+k].mesi[w] = ST_M;
            end
            vecs[7+k].chk_victim = 1'b1;
            vecs[7+k].victim = (k < 8) ? seq_victims[k] : 3'd0;
            vecs[7+k].dirty = 1'b1;
        end

        // Reset state
        bus.req_valid = 1'b0; bus.req_index = '0; bus.req_tag = '0;
        bus.req_tags = '0; bus.req_mesi = '0; bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.req_ready", 32'(bus.req_ready), 32'd1);
        check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst.hit",       32'(bus.rsp_hit), 32'd0);
        check("rst.way",       32'(bus.rsp_way), 32'd0);
        check("rst.multi",     32'(bus.rsp_multi_hit), 32'd0);
        check("rst.victim",    32'(bus.rsp_victim), 32'd0);
        check("rst.dirty",     32'(bus.rsp_victim_dirty), 32'd0);
        rstb = 1'b1;

        for (int i = 0; i < 16; i++) begin
            lookup(vecs[i].idx, vecs[i].tag, vecs[i].tags, vecs[i].mesi);
            check($sformatf("v%0d.latency", i), 32'(r_lat), 32'd1);
            check($sformatf("v%0d.hit", i), 32'(r_hit), 32'(vecs[i].hit));
            check($sformatf("v%0d.way", i), 32'(r_way), 32'(vecs[i].way));
            check($sformatf("v%0d.multi", i), 32'(r_multi), 32'(vecs[i].multi));
            if (vecs[i].chk_victim) begin
                check($sformatf("v%0d.victim", i), 32'(r_victim), 32'(vecs[i].victim));
                check($sformatf("v%0d.dirty", i), 32'(r_dirty), 32'(vecs[i].dirty));
            end
            $display("vec %0d: idx=%0d tag=%03h hit=%0d way=%0d multi=%0d victim=%0d dirty=%0d",
                     i, vecs[i].idx, vecs[i].tag, r_hit, r_way, r_multi, r_victim, r_dirty);
        end

        // Stall: A hit way1, B miss -> way4 (sees A's update), C miss -> way2 dirty
        for (int w = 0; w < WAYS; w++) begin
            ta[w] = 12'h010 + 12'(w);
            ma[w] = ST_S;
        end
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        drive(14'd20, 12'h011, ta, ma);
        check("stall.ready_a", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        drive(14'd20, 12'h0EE, ta, ma);
        @(negedge clk);
        for (int w = 0; w < WAYS; w++) ma[w] = ST_M;
        drive(14'd20, 12'h0EE, ta, ma);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("stall%0d.rsp_valid", k), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("stall%0d.hit", k), 32'(bus.rsp_hit), 32'd1);
            check($sformatf("stall%0d.way", k), 32'(bus.rsp_way), 32'd1);
            check($sformatf("stall%0d.req_ready", k), 32'(bus.req_ready), 32'd0);
            $display("stall cycle %0d: rsp_valid=%0d way=%0d req_ready=%0d",
                     k, bus.rsp_valid, bus.rsp_way, bus.req_ready);
            if (k < 3) @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("stall.ready_release", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("stall.b_valid", 32'(bus.rsp_valid), 32'd1);
        check("stall.b_hit", 32'(bus.rsp_hit), 32'd0);
        check("stall.b_victim", 32'(bus.rsp_victim), 32'd4);
        check("stall.b_dirty", 32'(bus.rsp_victim_dirty), 32'd0);
        $display("stall B: hit=%0d victim=%0d dirty=%0d", bus.rsp_hit, bus.rsp_victim, bus.rsp_victim_dirty);
        @(negedge clk);
        check("stall.c_valid", 32'(bus.rsp_valid), 32'd1);
        check("stall.c_hit", 32'(bus.rsp_hit), 32'd0);
        check("stall.c_victim", 32'(bus.rsp_victim), 32'd2);
        check("stall.c_dirty", 32'(bus.rsp_victim_dirty), 32'd1);
        $display("stall C: hit=%0d victim=%0d dirty=%0d", bus.rsp_hit, bus.rsp_victim, bus.rsp_victim_dirty);
        @(negedge clk);
        check("stall.drain", 32'(bus.rsp_valid), 32'd0);

        // Reset with both stages full
        for (int w = 0; w < WAYS; w++) begin
            ta[w] = 12'h300 + 12'(w);
            ma[w] = ST_M;
        end
        lookup(14'd30, 12'h3FF, ta, ma);
        check("rsti.first_victim", 32'(r_victim), 32'd0);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        drive(14'd30, 12'h3FF, ta, ma);
        @(negedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rsti.out_valid", 32'(bus.rsp_valid), 32'd1);
        check("rsti.out_victim", 32'(bus.rsp_victim), 32'd4);
        check("rsti.s1_full", 32'(bus.req_ready), 32'd0);
        rstb = 1'b0;
        #1;
        check("rsti.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rsti.req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rstb = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("rsti.quiet%0d", k), 32'(bus.rsp_valid), 32'd0);
        end
        lookup(14'd30, 12'h3FF, ta, ma);
        check("rsti.latency", 32'(r_lat), 32'd1);
        check("rsti.victim", 32'(r_victim), 32'd0);
        check("rsti.dirty", 32'(r_dirty), 32'd1);
        $display("reset recovery: victim=%0d dirty=%0d", r_victim, r_dirty);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
